// File: rtl/nld_atanh_core_16.sv
// nld_atanh_core_16: inverse tanh waveshaper, Q1.15 in -> Q3.13 out.
// Four-stage valid/ready pipeline with a single global advance enable.
// Optional macro NLD_ATANH_INTERP_EN enables linear interpolation between
// adjacent LUT entries; when undefined the lower entry is used directly.
module nld_atanh_core_16 #(
    parameter int unsigned LUT_AW = 8,
    parameter int unsigned FRAC_W = 7,
    parameter int unsigned ACC_W  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        m_last
);
    localparam int NumSeg = 2 ** LUT_AW;
    localparam logic signed [ACC_W-1:0] RMax = ACC_W'(32'h7FFF);

    // LUT[i] = round(atanh(i/NumSeg) * 8192), saturated to 0x7FFF; the
    // entry at NumSeg (atanh(1)) always saturates.
    function automatic logic [15:0] lut_entry(input int i);
        real x;
        real v;
        if (i >= NumSeg) return 16'h7FFF;
        x = real'(i) / real'(NumSeg);
        v = 0.5 * $ln((1.0 + x) / (1.0 - x)) * 8192.0 + 0.5;
        if (v >= 32767.0) return 16'h7FFF;
        return 16'($rtoi(v));
    endfunction

    logic [15:0] lut [0:NumSeg];
    for (genvar gi = 0; gi <= NumSeg; gi++) begin : g_lut
        assign lut[gi] = lut_entry(gi);
    end

    logic        adv;
    logic        rdy_q;
    logic        in_fire;
    logic [14:0] abs_in;

    logic        v1_q, sign1_q, last1_q;
    logic [14:0] a1_q;
    logic [LUT_AW:0] idx0;

    logic        v2_q, sign2_q, last2_q;
    logic [15:0] l0_q;
`ifdef NLD_ATANH_INTERP_EN
    logic [LUT_AW:0]   idx1;
    logic [15:0]       l1_q;
    logic [FRAC_W-1:0] frac2_q;
    logic signed [ACC_W-1:0] l0_x, l1_x, fr_x, prod;
`else
    logic unused_frac;
`endif

    logic signed [ACC_W-1:0] acc;
    logic [14:0] r_c;
    logic        v3_q, sign3_q, last3_q;
    logic [14:0] r3_q;

    // Whole pipe moves together; output stage frees up when empty or drained.
    assign adv     = !m_valid || m_ready;
    assign s_ready = rdy_q && adv;
    assign in_fire = s_valid && s_ready;

    // Input ready comes up one edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_q <= 1'b0;
        else     rdy_q <= 1'b1;
    end

    // Magnitude with the -1.0 input clamped to the largest positive code.
    always_comb begin
        abs_in = s_data[15] ? (~s_data[14:0] + 15'd1) : s_data[14:0];
        if (s_data == 16'h8000) abs_in = 15'h7FFF;
    end

    // Stage 1: sign and magnitude.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            a1_q    <= '0;
            last1_q <= 1'b0;
        end else if (adv) begin
            v1_q    <= in_fire;
            sign1_q <= s_data[15];
            a1_q    <= abs_in;
            last1_q <= s_last;
        end
    end

    assign idx0 = {1'b0, a1_q[FRAC_W +: LUT_AW]};
`ifdef NLD_ATANH_INTERP_EN
    assign idx1 = idx0 + {{LUT_AW{1'b0}}, 1'b1};
`else
    assign unused_frac = ^a1_q[FRAC_W-1:0];
`endif

    // Stage 2: LUT lookup of the segment endpoint(s).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            last2_q <= 1'b0;
            l0_q    <= '0;
`ifdef NLD_ATANH_INTERP_EN
            l1_q    <= '0;
            frac2_q <= '0;
`endif
        end else if (adv) begin
            v2_q    <= v1_q;
            sign2_q <= sign1_q;
            last2_q <= last1_q;
            l0_q    <= lut[idx0];
`ifdef NLD_ATANH_INTERP_EN
            l1_q    <= lut[idx1];
            frac2_q <= a1_q[FRAC_W-1:0];
`endif
        end
    end

    // Interpolated magnitude, clamped to [0, 0x7FFF].
    always_comb begin
`ifdef NLD_ATANH_INTERP_EN
        l0_x = $signed(ACC_W'(l0_q));
        l1_x = $signed(ACC_W'(l1_q));
        fr_x = $signed(ACC_W'(frac2_q));
        prod = (l1_x - l0_x) * fr_x;
        acc  = l0_x + (prod >>> FRAC_W);
`else
        acc  = $signed(ACC_W'(l0_q));
`endif
        if (acc[ACC_W-1])   r_c = '0;
        else if (acc > RMax) r_c = 15'h7FFF;
        else                 r_c = acc[14:0];
    end

    // Stage 3: magnitude result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q    <= 1'b0;
            sign3_q <= 1'b0;
            last3_q <= 1'b0;
            r3_q    <= '0;
        end else if (adv) begin
            v3_q    <= v2_q;
            sign3_q <= sign2_q;
            last3_q <= last2_q;
            r3_q    <= r_c;
        end
    end

    // Stage 4: restore sign; data only updates on a real sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (adv) begin
            m_valid <= v3_q;
            if (v3_q) begin
                m_data <= sign3_q ? -{1'b0, r3_q} : {1'b0, r3_q};
                m_last <= last3_q;
            end
        end
    end

endmodule

// File: tb/tb_nld_atanh_core_16.sv
// Self-checking bench for nld_atanh_core_16 with a scoreboard-driven
// arithmetic reference model. Honours NLD_ATANH_INTERP_EN like the DUT.
module tb_nld_atanh_core_16;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_data;
    logic        m_last;

    nld_atanh_core_16 dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: atanh table from real math, then plain integer arithmetic.
    int lut_ref [0:256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            real x;
            real v;
            x = real'(i) / 256.0;
            v = 0.5 * $ln((1.0 + x) / (1.0 - x)) * 8192.0 + 0.5;
            lut_ref[i] = (v >= 32767.0) ? 32767 : $rtoi(v);
        end
        lut_ref[256] = 32767;
    end

    function automatic logic [15:0] ref_atanh(input logic [15:0] y);
        int yv, a, idx, r;
        yv = int'($signed(y));
        a  = (yv < 0) ? -yv : yv;
        if (a > 32767) a = 32767;
        idx = a / 128;
`ifdef NLD_ATANH_INTERP_EN
        r = lut_ref[idx] + ((lut_ref[idx + 1] - lut_ref[idx]) * (a % 128)) / 128;
`else
        r = lut_ref[idx];
`endif
        if (r > 32767) r = 32767;
        if (r < 0) r = 0;
        return (yv < 0) ? 16'(-r) : 16'(r);
    endfunction

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
        logic        last;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [15:0] dout;
        logic        last;
        int          lat;
        int          cyc;
    } obs_t;

    exp_t        sb [$];
    obs_t        obs_q [$];
    logic [15:0] res [0:65535];
    int          cyc = 0;
    int          vcnt = 0;
    logic        hold_prev = 1'b0;
    logic [15:0] hold_data = '0;
    logic        hold_last = 1'b0;
    exp_t        e;

    // Monitor: sample mid-cycle, score transfers and output stability.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            hold_prev = 1'b0;
        end else begin
            if (m_valid) vcnt++;
            if (hold_prev) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(hold_data));
                check("hold_last", 32'(m_last), 32'(hold_last));
            end
            hold_prev = m_valid && !m_ready;
            hold_data = m_data;
            hold_last = m_last;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'(m_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("data", 32'(m_data), 32'(e.dout));
                    check("last", 32'(m_last), 32'(e.last));
                    obs_q.push_back('{dout: m_data, last: m_last, lat: cyc - e.cyc, cyc: cyc});
                    res[e.din] = m_data;
                end
            end
            if (s_valid && s_ready)
                sb.push_back('{din: s_data, dout: ref_atanh(s_data), last: s_last, cyc: cyc});
        end
    end

    task automatic push(input logic [15:0] d, input logic l, output int waits);
        logic ok;
        waits = 0;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!ok && waits < 1000) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            if (!ok) waits++;
        end
        s_valid = 1'b0;
        if (!ok) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || m_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, w1;
        logic [15:0] ramp [8];
        logic [15:0] exp_8000;
        logic [15:0] y;
`ifdef NLD_ATANH_INTERP_EN
        exp_8000 = 16'h803A;
`else
        exp_8000 = 16'h9C38;
`endif
        // Reset state and ready release.
        #3;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_pre_edge", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_post_edge", 32'(s_ready), 32'd1);

        // Zero input, latency and single-cycle valid.
        obs_q.delete();
        vcnt = 0;
        push(16'h0000, 1'b0, w0);
        drain();
        check("zero_count", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() >= 1) begin
            check("zero_data", 32'(obs_q[0].dout), 32'h0);
            check("zero_lat", 32'(obs_q[0].lat), 32'd4);
        end
        check("zero_vcycles", 32'(vcnt), 32'd1);

        // Back-to-back +0.5 / -0.5.
        obs_q.delete();
        push(16'h4000, 1'b0, w0);
        push(16'hC000, 1'b1, w1);
        check("pair_wait0", 32'(w0), 32'd0);
        check("pair_wait1", 32'(w1), 32'd0);
        drain();
        check("pair_count", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() >= 2) begin
            check("pair_pos", 32'(obs_q[0].dout), 32'h1194);
            check("pair_neg", 32'(obs_q[1].dout), 32'hEE6C);
            check("pair_consec", 32'(obs_q[1].cyc - obs_q[0].cyc), 32'd1);
            check("pair_last", 32'(obs_q[1].last), 32'd1);
        end

        // Most negative input clamps.
        obs_q.delete();
        push(16'h8000, 1'b0, w0);
        drain();
        check("neg1_count", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() >= 1) check("neg1_data", 32'(obs_q[0].dout), 32'(exp_8000));

        // Backpressure with a full pipe.
        for (int k = 0; k < 8; k++) ramp[k] = 16'(32'(k) * 32'h0F37 - 32'h3000);
        obs_q.delete();
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(ramp[k], 1'b0, w0);
        s_valid = 1'b1;
        s_data  = ramp[4];
        s_last  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready", 32'(s_ready), 32'd0);
            check("bp_valid", 32'(m_valid), 32'd1);
            check("bp_data", 32'(m_data), 32'(ref_atanh(ramp[0])));
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        for (int k = 4; k < 8; k++) push(ramp[k], k == 7, w0);
        drain();
        check("bp_count", 32'(obs_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
            check("bp_order", 32'(obs_q[k].dout), 32'(ref_atanh(ramp[k])));
            check("bp_lastflag", 32'(obs_q[k].last), 32'(k == 7));
        end

        // Reset with samples in flight.
        for (int k = 0; k < 4; k++) push(16'(16'h1000 + k * 16'h0100), 1'b0, w0);
        check("rst_pre_valid", 32'(m_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(m_valid), 32'd0);
        check("rst_async_data", 32'(m_data), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        obs_q.delete();
        repeat (5) begin
            @(negedge clk);
            check("rst_no_stale", 32'(m_valid), 32'd0);
            @(posedge clk); #1;
        end
        push(16'h2000, 1'b0, w0);
        drain();
        check("rst_new_count", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() >= 1) begin
            check("rst_new_data", 32'(obs_q[0].dout), 32'(ref_atanh(16'h2000)));
            check("rst_new_lat", 32'(obs_q[0].lat), 32'd4);
        end

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 16'($urandom);
            s_last  = 1'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        drain();

        // Exhaustive sweep at full rate.
        s_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            s_data = 16'(i);
            s_last = 1'(i);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        drain();
        check("sweep_empty", 32'(sb.size()), 32'd0);

        // Odd symmetry on random points.
        for (int k = 0; k < 64; k++) begin
            y = 16'($urandom_range(1, 32767));
            check("odd_sym", 32'(res[16'(-y)]), 32'(16'(-res[y])));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
